// File: rtl/clk_meas_pkg.sv
// Shared definitions for the divided-clock measurement blocks.
//   LOG2_W       : width of the log2 ratio output
//   meas_state_e : measurement FSM states
//   within_tol   : |a - b| <= tol compare used for period matching
package clk_meas_pkg;

    localparam int unsigned LOG2_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StMeasure,
        StLocked
    } meas_state_e;

    function automatic logic within_tol(logic [31:0] a, logic [31:0] b, logic [31:0] tol);
        logic [31:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous slow clock/strobe, plus one history
// flop for edge detection.
//   clk      : destination clock
//   reset    : synchronous, active-high; clears the synchronizer chain
//   sig_in   : asynchronous input
//   sig_sync : synchronized level
//   rise_det : one-cycle pulse on a synchronized rising edge
//   fall_det : one-cycle pulse on a synchronized falling edge
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_sync,
    output logic rise_det,
    output logic fall_det
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= sig_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sig_sync = sync_q;
    assign rise_det = sync_q & ~prev_q;
    assign fall_det = ~sync_q & prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of an asynchronous slow clock in clk
// cycles, reports the division ratio and declares lock once the ratio has been
// stable for LOCK_COUNT consecutive periods.
//   clk, reset   : measurement clock, synchronous active-high reset
//   enable       : 1 = measure, 0 = idle (counters, locked, timeout cleared)
//   sig_in       : asynchronous clock under test
//   period       : last rise-to-rise period in clk cycles
//   high_time    : synced high cycles within that period
//   period_valid : one-cycle pulse when period/high_time update
//   locked       : ratio stable for LOCK_COUNT consecutive periods
//   timeout      : sticky, no rising edge within 2^CNT_W-1 cycles
//   is_pow2      : period is an exact power of two (>= 2)
//   log2_ratio   : log2(period) when is_pow2, else 0
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TOL        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              period_valid,
    output logic              locked,
    output logic              timeout,
    output logic              is_pow2,
    output logic [LOG2_W-1:0] log2_ratio
);

    logic sig_sync;
    logic rise_det;
    logic fall_det_unused;

    sync_edge_det u_sync (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (sig_in),
        .sig_sync (sig_sync),
        .rise_det (rise_det),
        .fall_det (fall_det_unused)
    );

    meas_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  hcnt_q;
    logic [3:0]        match_q;
    // Set for the first period after SEEK, whose predecessor is stale.
    logic              first_q;
    logic              pow2_d;
    logic [LOG2_W-1:0] log2_d;
    logic              is_match;

    // Priority encode of the count about to be latched as period.
    always_comb begin
        pow2_d = 1'b0;
        log2_d = '0;
        for (int i = 1; i < int'(CNT_W); i++) begin
            if (cnt_q == (CNT_W'(1) << i)) begin
                pow2_d = 1'b1;
                log2_d = LOG2_W'(i);
            end
        end
    end

    assign is_match = !first_q && within_tol(32'(cnt_q), 32'(period), 32'(TOL));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            match_q      <= '0;
            first_q      <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            is_pow2      <= 1'b0;
            log2_ratio   <= '0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                // Period-derived outputs deliberately hold their last values.
                state_q <= StIdle;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                match_q <= '0;
                first_q <= 1'b0;
                locked  <= 1'b0;
                timeout <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StSeek;
                    StSeek: begin
                        if (rise_det) begin
                            state_q <= StMeasure;
                            cnt_q   <= CNT_W'(1);
                            hcnt_q  <= CNT_W'(1);
                            match_q <= '0;
                            first_q <= 1'b1;
                        end
                    end
                    StMeasure, StLocked: begin
                        if (rise_det) begin
                            // Synced sig is high on the rise cycle, so it counts.
                            cnt_q        <= CNT_W'(1);
                            hcnt_q       <= CNT_W'(1);
                            period       <= cnt_q;
                            high_time    <= hcnt_q;
                            is_pow2      <= pow2_d;
                            log2_ratio   <= log2_d;
                            period_valid <= 1'b1;
                            first_q      <= 1'b0;
                            if (is_match) begin
                                if (32'(match_q) < LOCK_COUNT) begin
                                    match_q <= match_q + 4'd1;
                                end
                                if ((32'(match_q) + 32'd1) >= LOCK_COUNT) begin
                                    state_q <= StLocked;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                match_q <= '0;
                                locked  <= 1'b0;
                                state_q <= StMeasure;
                            end
                        end else if (cnt_q == {CNT_W{1'b1}}) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            match_q <= '0;
                            cnt_q   <= '0;
                            hcnt_q  <= '0;
                            state_q <= StSeek;
                        end else begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            hcnt_q <= hcnt_q + CNT_W'(sig_sync);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
